gcd_bus_master: RTL and testbench

Bus initiator that drives the GCD peripheral's register interface: `saddress`, `srd`, `swr`, and the data buses. It accepts operand pairs over a valid/ready command port and runs a fixed bus sequence:

- writes A1 and A2;
- issues start;
- polls the status register until the busy bit clears;
- reads W and returns it on a valid/ready response port.

It sits between CPU-side logic and the peripheral and replaces hand-written bus sequencing.

---
 rtl/gcd_bus_pkg.sv | 24 ++
 rtl/gcd_bus_access.sv | 111 +++++++++++
 rtl/gcd_bus_master.sv | 186 ++++++++++++++++++
 tb/tb_gcd_bus_master.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_bus_pkg.sv
// Shared register map, status bit positions and job FSM states for the GCD
// peripheral bus master.
package gcd_bus_pkg;

  localparam logic [15:0] ADDR_A1 = 16'h00F8;
  localparam logic [15:0] ADDR_A2 = 16'h00FC;
  localparam logic [15:0] ADDR_W  = 16'h0100;
  localparam logic [15:0] ADDR_S  = 16'h0104;

  localparam int S_BUSY_BIT  = 3;
  localparam int S_START_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_A1,
    ST_WR_A2,
    ST_WR_START,
    ST_POLL_GAP_WAIT,
    ST_POLL_RD,
    ST_RD_W,
    ST_RESP
  } state_e;

endpackage

// File: rtl/gcd_bus_access.sv
// Single-transfer bus engine: SETUP, STROBE_CYCLES of strobe, HOLD. A request
// presented during HOLD chains straight into the next SETUP.
module gcd_bus_access #(
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic [15:0] saddress,
  output logic        srd,
  output logic        swr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] PH_IDLE   = 2'd0;
  localparam logic [1:0] PH_SETUP  = 2'd1;
  localparam logic [1:0] PH_STROBE = 2'd2;
  localparam logic [1:0] PH_HOLD   = 2'd3;

  localparam logic [31:0] STROBE_LAST = 32'(STROBE_CYCLES - 1);

  logic [1:0]  phase_q, phase_d;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        we_q, we_d;
  logic        srd_q, srd_d;
  logic        swr_q, swr_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
    phase_d = phase_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    srd_d   = srd_q;
    swr_d   = swr_q;
    case (phase_q)
      PH_IDLE, PH_HOLD: begin
        if (req) begin
          phase_d = PH_SETUP;
          addr_d  = addr;
          wdata_d = we ? wdata : '0;
          we_d    = we;
        end else begin
          phase_d = PH_IDLE;
          addr_d  = '0;
          wdata_d = '0;
          we_d    = 1'b0;
        end
      end
      PH_SETUP: begin
        phase_d = PH_STROBE;
        cnt_d   = '0;
        srd_d   = ~we_q;
        swr_d   = we_q;
      end
      default: begin
        if (cnt_q == STROBE_LAST) begin
          phase_d = PH_HOLD;
          srd_d   = 1'b0;
          swr_d   = 1'b0;
          // Sampled on the last strobe cycle, well after the rising edge.
          if (!we_q) rdata_d = bus_rdata;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
    endcase
  end

  // NOTE: asynchronous reset in the sensitivity list; state updates use non-blocking assignments.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      srd_q   <= 1'b0;
      swr_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      srd_q   <= srd_d;
      swr_q   <= swr_d;
    end
  end

  assign done      = (phase_q == PH_HOLD);
  assign rdata     = rdata_q;
  assign saddress  = addr_q;
  assign bus_wdata = wdata_q;
  assign srd       = srd_q;
  assign swr       = swr_q;

endmodule

// File: rtl/gcd_bus_master.sv
// Job sequencer for the GCD peripheral: writes operands, starts, polls status
// and returns the result (or a timeout) over a valid/ready response port.
module gcd_bus_master
  import gcd_bus_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned POLL_GAP      = 4,
  parameter int unsigned TIMEOUT_POLLS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_gcd,
  output logic        rsp_timeout,
  output logic [15:0] saddress,
  output logic        srd,
  output logic        swr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  output logic        busy
);

  localparam logic [31:0] GAP_LAST  = 32'(POLL_GAP - 1);
  localparam logic [31:0] START_CMD = 32'h1 << S_START_BIT;

  state_e      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic [31:0] b_q, b_d;
  logic [31:0] poll_q, poll_d, poll_inc;
  logic [31:0] gap_q, gap_d;
  logic [31:0] gcd_q, gcd_d;
  logic        to_q, to_d;

  logic        acc_req, acc_we, acc_done;
  logic [15:0] acc_addr;
  logic [31:0] acc_wdata, acc_rdata;

  assign poll_inc = (&poll_q) ? poll_q : poll_q + 32'd1;

  // Each access request is raised on the transition into its state, so the
  // engine chains accesses without extra idle cycles.
  always_comb begin
    state_d   = state_q;
    b_d       = b_q;
    poll_d    = poll_q;
    gap_d     = gap_q;
    gcd_d     = gcd_q;
    to_d      = to_q;
    acc_req   = 1'b0;
    acc_we    = 1'b0;
    acc_addr  = '0;
    acc_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          b_d    = cmd_b;
          poll_d = '0;
          to_d   = 1'b0;
          // The peripheral never finishes on a zero operand, so answer locally.
          if (cmd_a == '0 || cmd_b == '0) begin
            gcd_d   = cmd_a | cmd_b;
            state_d = ST_RESP;
          end else begin
            state_d   = ST_WR_A1;
            acc_req   = 1'b1;
            acc_we    = 1'b1;
            acc_addr  = ADDR_A1;
            acc_wdata = cmd_a;
          end
        end
      end
      ST_WR_A1: begin
        if (acc_done) begin
          state_d   = ST_WR_A2;
          acc_req   = 1'b1;
          acc_we    = 1'b1;
          acc_addr  = ADDR_A2;
          acc_wdata = b_q;
        end
      end
      ST_WR_A2: begin
        if (acc_done) begin
          state_d   = ST_WR_START;
          acc_req   = 1'b1;
          acc_we    = 1'b1;
          acc_addr  = ADDR_S;
          acc_wdata = START_CMD;
        end
      end
      ST_WR_START: begin
        if (acc_done) begin
          state_d = ST_POLL_GAP_WAIT;
          gap_d   = '0;
        end
      end
      ST_POLL_GAP_WAIT: begin
        if (gap_q == GAP_LAST) begin
          state_d  = ST_POLL_RD;
          acc_req  = 1'b1;
          acc_addr = ADDR_S;
        end else begin
          gap_d = gap_q + 32'd1;
        end
      end
      ST_POLL_RD: begin
        if (acc_done) begin
          poll_d = poll_inc;
          if (!acc_rdata[S_BUSY_BIT]) begin
            state_d  = ST_RD_W;
            acc_req  = 1'b1;
            acc_addr = ADDR_W;
          end else if (poll_inc >= TIMEOUT_POLLS) begin
            state_d = ST_RESP;
            to_d    = 1'b1;
            gcd_d   = '0;
          end else begin
            state_d = ST_POLL_GAP_WAIT;
            gap_d   = '0;
          end
        end
      end
      ST_RD_W: begin
        if (acc_done) begin
          gcd_d   = acc_rdata;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready_d = (state_d == ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      b_q         <= '0;
      poll_q      <= '0;
      gap_q       <= '0;
      gcd_q       <= '0;
      to_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      b_q         <= b_d;
      poll_q      <= poll_d;
      gap_q       <= gap_d;
      gcd_q       <= gcd_d;
      to_q        <= to_d;
    end
  end

  gcd_bus_access #(
    .STROBE_CYCLES(STROBE_CYCLES)
  ) u_access (
    .clk      (clk),
    .reset    (reset),
    .req      (acc_req),
    .we       (acc_we),
    .addr     (acc_addr),
    .wdata    (acc_wdata),
    .done     (acc_done),
    .rdata    (acc_rdata),
    .saddress (saddress),
    .srd      (srd),
    .swr      (swr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata)
  );

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_gcd     = gcd_q;
  assign rsp_timeout = to_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gcd_bus_master.sv
// Directed plus randomized bench for gcd_bus_master against a behavioural GCD
// peripheral model and a bus access log.
module tb_gcd_bus_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] cmd_a, cmd_b, rsp_gcd, bus_wdata, bus_rdata;
  logic [15:0] saddress;
  logic        srd, swr, busy;

  int errors = 0;
  int checks = 0;

  gcd_bus_master #(
    .STROBE_CYCLES(2),
    .POLL_GAP     (4),
    .TIMEOUT_POLLS(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_gcd    (rsp_gcd),
    .rsp_timeout(rsp_timeout),
    .saddress   (saddress),
    .srd        (srd),
    .swr        (swr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] data;
    int          len;
  } acc_t;

  acc_t        log_q[$];
  int          overlap_err = 0;
  int          stab_err = 0;

  logic [31:0] per_a1 = '0, per_a2 = '0, per_w = '0;
  logic        per_busy = 1'b0;
  int          per_cnt = 0;
  logic        hold_busy = 1'b0;
  int          busy_dur = 3;

  function automatic logic [31:0] ref_gcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  assign bus_rdata = (saddress == 16'h0100) ? per_w :
                     (saddress == 16'h0104) ? (32'(per_busy) << 3) : 32'h0;

  // Peripheral model and bus monitor, both evaluated away from the active edge.
  initial begin
    logic swr_prev, srd_prev, in_acc;
    acc_t cur;
    swr_prev = 1'b0;
    srd_prev = 1'b0;
    in_acc   = 1'b0;
    cur      = '{we: 1'b0, addr: '0, data: '0, len: 0};
    forever begin
      @(negedge clk);
      if (srd && swr) overlap_err++;
      if ((swr && !swr_prev && srd_prev) || (srd && !srd_prev && swr_prev)) overlap_err++;
      if ((swr && !swr_prev) || (srd && !srd_prev)) begin
        cur    = '{we: swr, addr: saddress, data: (swr ? bus_wdata : 32'h0), len: 1};
        in_acc = 1'b1;
      end else if (in_acc && (swr || srd)) begin
        cur.len++;
        if (saddress != cur.addr || (cur.we && bus_wdata != cur.data)) stab_err++;
      end else if (in_acc) begin
        log_q.push_back(cur);
        in_acc = 1'b0;
      end

      if (per_busy && !hold_busy) begin
        if (per_cnt <= 1) per_busy = 1'b0;
        else per_cnt--;
      end
      if (swr && !swr_prev) begin
        case (saddress)
          16'h00F8: per_a1 = bus_wdata;
          16'h00FC: per_a2 = bus_wdata;
          16'h0104: if (bus_wdata[0]) begin
            per_w    = ref_gcd(per_a1, per_a2);
            per_busy = 1'b1;
            per_cnt  = busy_dur;
          end
          default: ;
        endcase
      end
      swr_prev = swr;
      srd_prev = srd;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [31:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("cmd_ready_seen", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
  endtask

  // Latency counted in cycles after the handshake cycle.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 2000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("rsp_valid_seen", 32'(rsp_valid), 32'd1);
  endtask

  task automatic take_rsp(input int delay, output logic [31:0] g, output logic to,
                          output int unstable);
    g        = rsp_gcd;
    to       = rsp_timeout;
    unstable = 0;
    for (int k = 0; k < delay; k++) begin
      @(posedge clk);
      #1;
      if (!rsp_valid || rsp_gcd !== g || rsp_timeout !== to || cmd_ready !== 1'b0 ||
          busy !== 1'b1) unstable++;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic run_job(input logic [31:0] a, input logic [31:0] b, input int delay,
                         output int lat, output logic [31:0] g, output logic to,
                         output int unstable);
    send_cmd(a, b);
    wait_rsp(lat);
    take_rsp(delay, g, to, unstable);
  endtask

  function automatic int count_acc(input logic we, input logic [15:0] addr);
    int n;
    n = 0;
    foreach (log_q[i]) if (log_q[i].we == we && log_q[i].addr == addr) n++;
    return n;
  endfunction

  initial begin
    int          lat, unstable, bad_len, guard, leaked;
    logic [31:0] g, a, b, exp_g;
    logic        to;

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    rsp_ready = 1'b0;

    // Reset values
    #2;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_gcd", rsp_gcd, 32'd0);
    check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    check("rst_saddress", 32'(saddress), 32'd0);
    check("rst_strobes", {30'b0, srd, swr}, 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // (48,18): bus sequence, strobe widths and 25-cycle latency with one poll
    busy_dur = 3;
    log_q.delete();
    run_job(32'd48, 32'd18, 0, lat, g, to, unstable);
    check("g48_18_gcd", g, 32'd6);
    check("g48_18_timeout", 32'(to), 32'd0);
    check("g48_18_latency", 32'(lat), 32'd25);
    check("g48_18_nacc", 32'(log_q.size()), 32'd5);
    check("g48_18_w0", {log_q[0].we, 15'b0, log_q[0].addr}, {1'b1, 15'b0, 16'h00F8});
    check("g48_18_d0", log_q[0].data, 32'd48);
    check("g48_18_w1", {log_q[1].we, 15'b0, log_q[1].addr}, {1'b1, 15'b0, 16'h00FC});
    check("g48_18_d1", log_q[1].data, 32'd18);
    check("g48_18_w2", {log_q[2].we, 15'b0, log_q[2].addr}, {1'b1, 15'b0, 16'h0104});
    check("g48_18_d2", log_q[2].data, 32'd1);
    check("g48_18_poll", {log_q[3].we, 15'b0, log_q[3].addr}, {1'b0, 15'b0, 16'h0104});
    check("g48_18_rdw", {log_q[4].we, 15'b0, log_q[4].addr}, {1'b0, 15'b0, 16'h0100});
    bad_len = 0;
    foreach (log_q[i]) if (log_q[i].len != 2) bad_len++;
    check("g48_18_strobe_len", 32'(bad_len), 32'd0);
    check("g48_18_idle_after", 32'(busy), 32'd0);

    // Zero-operand bypass: immediate answer, no bus traffic
    log_q.delete();
    run_job(32'd0, 32'd7, 0, lat, g, to, unstable);
    check("zero_0_7_gcd", g, 32'd7);
    check("zero_0_7_latency", 32'(lat), 32'd1);
    run_job(32'd0, 32'd0, 0, lat, g, to, unstable);
    check("zero_0_0_gcd", g, 32'd0);
    check("zero_0_0_latency", 32'(lat), 32'd1);
    check("zero_no_bus", 32'(log_q.size()), 32'd0);

    // Busy forever: four status reads, then timeout
    hold_busy = 1'b1;
    log_q.delete();
    run_job(32'd9, 32'd6, 0, lat, g, to, unstable);
    check("tmo_timeout", 32'(to), 32'd1);
    check("tmo_gcd", g, 32'd0);
    check("tmo_status_reads", 32'(count_acc(1'b0, 16'h0104)), 32'd4);
    check("tmo_no_w_read", 32'(count_acc(1'b0, 16'h0100)), 32'd0);
    check("tmo_latency", 32'(lat), 32'd45);
    hold_busy = 1'b0;

    // Response back-pressure
    busy_dur = 12;
    run_job(32'd1071, 32'd462, 10, lat, g, to, unstable);
    check("bp_gcd", g, 32'd21);
    check("bp_stable", 32'(unstable), 32'd0);
    check("bp_idle_after", 32'(busy), 32'd0);
    check("bp_cmd_ready_after", 32'(cmd_ready), 32'd1);

    // Reset in the middle of the A2 write strobe
    send_cmd(32'd100, 32'd75);
    guard = 0;
    while (!(swr && saddress == 16'h00FC) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("rst_mid_reached_a2", 32'(swr), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_swr", 32'(swr), 32'd0);
    check("rst_mid_saddress", 32'(saddress), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_cmd_ready", 32'(cmd_ready), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    leaked = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (rsp_valid) leaked++;
    end
    check("rst_mid_no_rsp", 32'(leaked), 32'd0);
    log_q.delete();
    busy_dur = 5;
    run_job(32'd12, 32'd8, 0, lat, g, to, unstable);
    check("after_rst_gcd", g, 32'd4);
    check("after_rst_a1", log_q[0].data, 32'd12);

    // Back-to-back commands
    run_job(32'd35, 32'd14, 0, lat, g, to, unstable);
    check("b2b_first", g, 32'd7);
    run_job(32'd17, 32'd5, 0, lat, g, to, unstable);
    check("b2b_second", g, 32'd1);

    // Randomized jobs against the reference GCD
    for (int i = 0; i < 8; i++) begin
      a        = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      b        = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom_range(1, 100000) * 6);
      busy_dur = $urandom_range(1, 30);
      exp_g    = ref_gcd(a, b);
      run_job(a, b, $urandom_range(0, 3), lat, g, to, unstable);
      check($sformatf("rand%0d_gcd", i), g, exp_g);
      check($sformatf("rand%0d_timeout", i), 32'(to), 32'd0);
      check($sformatf("rand%0d_stable", i), 32'(unstable), 32'd0);
      if (a == 0 || b == 0) check($sformatf("rand%0d_bypass_lat", i), 32'(lat), 32'd1);
    end

    check("no_strobe_overlap", 32'(overlap_err), 32'd0);
    check("bus_stable_in_strobe", 32'(stab_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
